rsa_result_collector: RTL and testbench

Downstream capture stage for the RSA core: it detects each rising edge of the core's `o_en` strobe and captures the accompanying 32-bit `result` word into an on-chip FIFO. It counts words per frame and flags frame completion and overflow. The FIFO drains through a valid/ready port towards the host or output interface.

---
 rtl/rsa_result_collector.sv | 151 +++++++++++++++
 tb/tb_rsa_result_collector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_result_collector.sv
// rsa_result_collector
//   Capture stage behind the RSA core. Every rising edge of o_en captures
//   the accompanying result word into an on-chip FIFO. Words are counted
//   per frame, and sticky flags report frame completion and dropped words.
//   The FIFO drains through a valid/ready port, independently of framing.
//
// Parameters
//   DATA_W     width of result / FIFO words
//   DEPTH      FIFO depth in words (power of two, >= 2)
//   NUM_WORDS  words per frame (1..1023)
//
// Ports
//   clk, rst     single clock, synchronous active-high reset
//   start        one-cycle pulse opening a new frame (FIFO is not flushed)
//   o_en, result core strobe and its data word
//   out_data     FIFO head word (0 while empty)
//   out_valid    FIFO non-empty
//   out_ready    consumer accepts the head word
//   level        FIFO occupancy, 0..DEPTH
//   frame_done   sticky: NUM_WORDS edges counted in this frame
//   overflow     sticky: at least one word dropped in this frame
//   checksum     running XOR of words written this frame
//                (port present only when RSA_COLLECT_CHECKSUM_EN is defined)
module rsa_result_collector #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     o_en,
  input  logic [DATA_W-1:0]        result,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_done,
  output logic                     overflow
`ifdef RSA_COLLECT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]        checksum
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t            state;
  logic              o_en_d;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  cnt_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              o_en_rise;
  logic              capture;
  logic              push;
  logic              drop;
  logic              pop;

  // A full FIFO still accepts the word when the head leaves in the same
  // cycle; start always takes priority over a coincident edge.
  always_comb begin
    o_en_rise = o_en & ~o_en_d;
    pop       = out_valid & out_ready;
    capture   = o_en_rise & ~start & (state == COLLECT);
    push      = capture & ((level != FULL_LVL) | pop);
    drop      = capture & ~push;
    cnt_next  = word_cnt + CNT_ONE;
  end

  always_comb begin
    out_valid = (level != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      o_en_d     <= 1'b0;
      word_cnt   <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
`ifdef RSA_COLLECT_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      o_en_d <= o_en;
      if (start) begin
        state      <= COLLECT;
        word_cnt   <= '0;
        frame_done <= 1'b0;
        overflow   <= 1'b0;
`ifdef RSA_COLLECT_CHECKSUM_EN
        checksum   <= '0;
`endif
      end else if (capture) begin
        // Dropped words still count towards the frame.
        word_cnt <= cnt_next;
        if (drop) overflow <= 1'b1;
`ifdef RSA_COLLECT_CHECKSUM_EN
        if (push) checksum <= checksum ^ result;
`endif
        if (cnt_next == LAST_CNT) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rsa_result_collector.sv
// Self-checking bench for rsa_result_collector (DEPTH=64, NUM_WORDS=70).
// A queue-based reference model predicts FIFO contents and frame flags.
module tb_rsa_result_collector;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned NW    = 70;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          o_en = 1'b0;
  logic [DW-1:0] result = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [6:0]    level;
  logic          frame_done;
  logic          overflow;
`ifdef RSA_COLLECT_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  rsa_result_collector #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .NUM_WORDS(NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .o_en      (o_en),
    .result    (result),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .frame_done(frame_done),
    .overflow  (overflow)
`ifdef RSA_COLLECT_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a word queue plus frame bookkeeping.
  logic [DW-1:0] m_q[$];
  logic          m_prev_oen = 1'b0;
  bit            m_open = 1'b0;
  int            m_cnt = 0;
  bit            m_done = 1'b0;
  bit            m_ovf = 1'b0;
  logic [DW-1:0] m_ck = '0;

  logic [DW-1:0] popped[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit rise, pop_now, push_now;
    if (rst) begin
      m_q.delete();
      m_prev_oen = 1'b0;
      m_open = 1'b0;
      m_cnt = 0;
      m_done = 1'b0;
      m_ovf = 1'b0;
      m_ck = '0;
      return;
    end
    rise     = o_en && !m_prev_oen;
    pop_now  = (m_q.size() != 0) && out_ready;
    push_now = 1'b0;
    if (start) begin
      m_open = 1'b1;
      m_cnt  = 0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
      m_ck   = '0;
    end else if (rise && m_open) begin
      m_cnt++;
      if (m_q.size() < DEPTH || pop_now) push_now = 1'b1;
      else m_ovf = 1'b1;
      if (push_now) m_ck ^= result;
      if (m_cnt == NW) begin
        m_open = 1'b0;
        m_done = 1'b1;
      end
    end
    if (pop_now) void'(m_q.pop_front());
    if (push_now) m_q.push_back(result);
    m_prev_oen = o_en;
  endtask

  task automatic check_outputs();
    chk("out_valid", DW'(out_valid), DW'(m_q.size() != 0));
    chk("level", DW'(level), DW'(m_q.size()));
    if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
    chk("frame_done", DW'(frame_done), DW'(m_done));
    chk("overflow", DW'(overflow), DW'(m_ovf));
`ifdef RSA_COLLECT_CHECKSUM_EN
    chk("checksum", checksum, m_ck);
`endif
  endtask

  task automatic tick();
    if (out_valid && out_ready) popped.push_back(out_data);
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse(input logic [DW-1:0] w, input int unsigned low);
    o_en = 1'b1;
    result = w;
    tick();
    o_en = 1'b0;
    repeat (low) tick();
  endtask

  task automatic drain(input int unsigned n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #1;
    // Reset
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_data", out_data, '0);
    chk("rst_level", DW'(level), '0);
    chk("rst_out_valid", DW'(out_valid), '0);

    // IDLE ignores edges
    pulse(32'h1234_5678, 2);
    chk("idle_no_capture", DW'(level), '0);

    // Full frame with continuous drain
    popped.delete();
    out_ready = 1'b1;
    do_start();
    for (int i = 1; i <= 70; i++) pulse(DW'(i), 3);
    tick();
    out_ready = 1'b0;
    chk("A_count", DW'(popped.size()), 32'd70);
    for (int i = 0; i < 70; i++) chk("A_seq", popped[i], DW'(i + 1));
    chk("A_done", DW'(frame_done), 32'd1);
    chk("A_ovf", DW'(overflow), 32'd0);
    chk("A_level", DW'(level), 32'd0);

    // Overflow with stalled consumer
    do_start();
    for (int i = 1; i <= 70; i++) pulse(DW'(i), 1);
    chk("B_level", DW'(level), 32'd64);
    chk("B_ovf", DW'(overflow), 32'd1);
    chk("B_done", DW'(frame_done), 32'd1);
    popped.delete();
    drain(66);
    chk("B_count", DW'(popped.size()), 32'd64);
    for (int i = 0; i < 64; i++) chk("B_seq", popped[i], DW'(i + 1));

    // Full FIFO, push and pop in the same cycle
    do_start();
    for (int i = 1; i <= 64; i++) pulse(DW'(100 + i), 1);
    chk("C_full", DW'(level), 32'd64);
    popped.delete();
    o_en = 1'b1;
    result = 32'h0000_DEAD;
    out_ready = 1'b1;
    tick();
    o_en = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("C_level", DW'(level), 32'd64);
    chk("C_ovf", DW'(overflow), 32'd0);
    drain(70);
    chk("C_count", DW'(popped.size()), 32'd65);
    chk("C_first", popped[0], 32'd101);
    chk("C_last", popped[64], 32'h0000_DEAD);

    // Long o_en level counts once
    do_start();
    o_en = 1'b1;
    result = $urandom;
    repeat (10) tick();
    o_en = 1'b0;
    tick();
    chk("D_level", DW'(level), 32'd1);
    drain(3);

    // start coincident with an edge, then rst mid-frame
    o_en = 1'b1;
    result = 32'hBAD0_0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    o_en = 1'b0;
    tick();
    chk("E_start_wins", DW'(level), 32'd0);
    for (int i = 0; i < 20; i++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      pulse($urandom, 1);
    end
    out_ready = 1'b0;
    o_en = 1'b1;
    result = $urandom;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("E_rst_level", DW'(level), '0);
    chk("E_rst_valid", DW'(out_valid), '0);
    chk("E_rst_data", out_data, '0);
    chk("E_rst_done", DW'(frame_done), '0);
    chk("E_rst_ovf", DW'(overflow), '0);
    repeat (2) tick();
    o_en = 1'b0;
    pulse($urandom, 2);
    chk("E_idle", DW'(level), '0);

    // Checksum of written words
    do_start();
    pulse(32'hA5A5_A5A5, 1);
    pulse(32'h0F0F_0F0F, 1);
`ifdef RSA_COLLECT_CHECKSUM_EN
    chk("F_checksum", checksum, 32'hAAAA_AAAA);
`endif
    do_start();
`ifdef RSA_COLLECT_CHECKSUM_EN
    chk("F_cleared", checksum, '0);
`endif
    drain(4);

    // Randomized traffic with varying drain pressure
    for (int blk = 0; blk < 6; blk++) begin
      int unsigned rdy_pct;
      rdy_pct = $urandom_range(5, 95);
      for (int c = 0; c < 500; c++) begin
        rst       = ($urandom_range(0, 699) == 0);
        start     = ($urandom_range(0, 249) == 0);
        o_en      = ($urandom_range(0, 1) == 1);
        result    = $urandom;
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        tick();
      end
    end
    rst = 1'b0;
    start = 1'b0;
    o_en = 1'b0;
    drain(DEPTH + 2);
    chk("G_empty", DW'(level), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
